// File: rtl/seq_pkg.sv
// Shared definitions for the seq_circuit Y run logger.
// State codes, default widths and the run record layout.
package seq_pkg;

  localparam logic [1:0] S1 = 2'b00;
  localparam logic [1:0] S2 = 2'b01;
  localparam logic [1:0] S3 = 2'b11;
  localparam logic [1:0] S4 = 2'b10;

  localparam int CNT_W_DEF = 8;
  localparam int TOT_W_DEF = 16;

  typedef struct packed {
    logic                 sat;
    logic [CNT_W_DEF-1:0] len;
  } run_rec_t;

endpackage

// File: rtl/run_fifo.sv
// Synchronous FIFO, power-of-two depth.
// A push while full without a pop is ignored.
module run_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr;
  logic          rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      unique case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seq_run_logger.sv
// Measures high runs of Y and queues their lengths.
// Keeps a completed-run total and a sticky drop flag.
module seq_run_logger
  import seq_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int TOT_W      = TOT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_len,
  output logic             out_sat,
  output logic [TOT_W-1:0] run_total,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LEN_MAX = '1;

  logic                        y_q;
  logic [CNT_W-1:0]            len;
  logic                        sat;
  logic                        run_end;
  logic                        pop;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [CNT_W:0]              head;

  assign run_end   = y_q && !y_in;
  assign pop       = out_ready && !empty;
  assign out_valid = (count != '0);
  assign out_sat   = head[CNT_W];
  assign out_len   = head[CNT_W-1:0];

  run_fifo #(
    .DW    (CNT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (run_end),
    .pop   (pop),
    .din   ({sat, len}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= 1'b0;
      len       <= '0;
      sat       <= 1'b0;
      run_total <= '0;
      ovf       <= 1'b0;
    end else begin
      y_q <= y_in;
      if (y_in && !y_q) begin
        len <= CNT_W'(1);
        sat <= 1'b0;
      end else if (y_in && y_q) begin
        if (len == LEN_MAX) sat <= 1'b1;
        else                len <= len + 1'b1;
      end
      // a full FIFO still accepts the record when the head leaves this edge
      if (run_end) begin
        run_total <= run_total + 1'b1;
        if (full && !pop) ovf <= 1'b1;
      end
    end
  end

endmodule
